// File: rtl/vme_reg_bank.sv
`default_nettype none
// ============================================================================
// vme_reg_bank : VME register bank with address decode, per-register reset
//                values and error acknowledge for unmapped word addresses.
//                Optional per-register write strobe: VME_REG_BANK_WSTROBE_EN
// Revision     : 1.0
// ============================================================================
module vme_reg_bank #(
   parameter int                         NREGS      = 4,
   parameter int                         REG_WIDTH  = 16,
   parameter int                         ADDR_WIDTH = 2,
   parameter logic [NREGS*REG_WIDTH-1:0] RESET_VALS = '0
) (
   input  logic                         Clk,
   input  logic                         rst_n,
   input  logic [ADDR_WIDTH-1:0]        VMEAddr,
   input  logic [31:0]                  VMEWrData,
   input  logic                         VMEWrMem,
   input  logic                         VMERdMem,
   output logic [31:0]                  VMERdData,
   output logic                         VMERdDone,
   output logic                         VMEWrDone,
   output logic                         VMERdError,
   output logic                         VMEWrError,
   output logic [NREGS*REG_WIDTH-1:0]   regs_o
`ifdef VME_REG_BANK_WSTROBE_EN
   ,
   output logic [NREGS-1:0]             wr_strobe_o
`endif
);

   // Full-width compare so address bits above clog2(NREGS) never alias
   localparam logic [ADDR_WIDTH:0] c_NREGS = NREGS[ADDR_WIDTH:0];

   logic                  wr_req_d0_q;
   logic [ADDR_WIDTH-1:0] wr_adr_d0_q;
   logic [REG_WIDTH-1:0]  wr_dat_d0_q;
   logic [REG_WIDTH-1:0]  regs_q [NREGS];
   logic                  wr_done_q;
   logic                  wr_err_q;
   logic                  rd_done_q;
   logic                  rd_err_q;
   logic [31:0]           rd_dat_q;
   logic [31:0]           rd_dat_d;
   logic [NREGS-1:0]      w_wr_hit;
   logic                  w_wr_mapped;
   logic                  w_rd_mapped;
   logic                  w_unused_wdata;

   assign w_unused_wdata = ^VMEWrData;

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_req_d0_q <= 1'b0;
         wr_adr_d0_q <= '0;
         wr_dat_d0_q <= '0;
      end else begin
         wr_req_d0_q <= VMEWrMem;
         wr_adr_d0_q <= VMEAddr;
         wr_dat_d0_q <= VMEWrData[REG_WIDTH-1:0];
      end
   end

   assign w_wr_mapped = ({1'b0, wr_adr_d0_q} < c_NREGS);

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_done_q <= 1'b0;
         wr_err_q  <= 1'b0;
      end else begin
         wr_done_q <= wr_req_d0_q;
         wr_err_q  <= wr_req_d0_q & ~w_wr_mapped;
      end
   end

   for (genvar i = 0; i < NREGS; i++) begin : g_reg
      localparam logic [ADDR_WIDTH-1:0] c_IDX = ADDR_WIDTH'(i);

      assign w_wr_hit[i] = wr_req_d0_q && (wr_adr_d0_q == c_IDX);

      always_ff @(posedge Clk or negedge rst_n) begin
         if (!rst_n) begin
            regs_q[i] <= RESET_VALS[i*REG_WIDTH +: REG_WIDTH];
         end else if (w_wr_hit[i]) begin
            regs_q[i] <= wr_dat_d0_q;
         end
      end

      assign regs_o[i*REG_WIDTH +: REG_WIDTH] = regs_q[i];
   end

`ifdef VME_REG_BANK_WSTROBE_EN
   logic [NREGS-1:0] wr_strobe_q;

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_strobe_q <= '0;
      end else begin
         wr_strobe_q <= w_wr_hit;
      end
   end

   assign wr_strobe_o = wr_strobe_q;
`endif

   // Unmapped addresses match no index and so read back as zero
   always_comb begin
      rd_dat_d = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (VMEAddr == ADDR_WIDTH'(i)) begin
            rd_dat_d = 32'(regs_q[i]);
         end
      end
   end

   assign w_rd_mapped = ({1'b0, VMEAddr} < c_NREGS);

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_done_q <= 1'b0;
         rd_err_q  <= 1'b0;
         rd_dat_q  <= '0;
      end else begin
         rd_done_q <= VMERdMem;
         rd_err_q  <= VMERdMem & ~w_rd_mapped;
         if (VMERdMem) begin
            rd_dat_q <= rd_dat_d;
         end
      end
   end

   assign VMERdData  = rd_dat_q;
   assign VMERdDone  = rd_done_q;
   assign VMERdError = rd_err_q;
   assign VMEWrDone  = wr_done_q;
   assign VMEWrError = wr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vme_reg_bank.sv
`default_nettype none
// ============================================================================
// tb_vme_reg_bank : bench for vme_reg_bank, two instances (NREGS=4 and NREGS=3)
//                   sharing one stimulus stream, against an event-queue model.
// Revision        : 1.0
// ============================================================================
module tb_vme_reg_bank;

   logic        Clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  VMEAddr = '0;
   logic [31:0] VMEWrData = '0;
   logic        VMEWrMem = 1'b0;
   logic        VMERdMem = 1'b0;

   logic [31:0] a_rd_data, b_rd_data;
   logic        a_rd_done, b_rd_done, a_wr_done, b_wr_done;
   logic        a_rd_err, b_rd_err, a_wr_err, b_wr_err;
   logic [63:0] a_regs;
   logic [47:0] b_regs;
   logic [3:0]  a_strb;
   logic [2:0]  b_strb;

   always #5 Clk = ~Clk;

   vme_reg_bank #(
      .NREGS(4), .REG_WIDTH(16), .ADDR_WIDTH(2),
      .RESET_VALS(64'hD004_C003_B002_A001)
   ) u_dut_a (
      .Clk(Clk), .rst_n(rst_n), .VMEAddr(VMEAddr), .VMEWrData(VMEWrData),
      .VMEWrMem(VMEWrMem), .VMERdMem(VMERdMem), .VMERdData(a_rd_data),
      .VMERdDone(a_rd_done), .VMEWrDone(a_wr_done), .VMERdError(a_rd_err),
      .VMEWrError(a_wr_err), .regs_o(a_regs)
`ifdef VME_REG_BANK_WSTROBE_EN
      , .wr_strobe_o(a_strb)
`endif
   );

   vme_reg_bank #(
      .NREGS(3), .REG_WIDTH(16), .ADDR_WIDTH(2),
      .RESET_VALS(48'h3C3C_2B2B_1A1A)
   ) u_dut_b (
      .Clk(Clk), .rst_n(rst_n), .VMEAddr(VMEAddr), .VMEWrData(VMEWrData),
      .VMEWrMem(VMEWrMem), .VMERdMem(VMERdMem), .VMERdData(b_rd_data),
      .VMERdDone(b_rd_done), .VMEWrDone(b_wr_done), .VMERdError(b_rd_err),
      .VMEWrError(b_wr_err), .regs_o(b_regs)
`ifdef VME_REG_BANK_WSTROBE_EN
      , .wr_strobe_o(b_strb)
`endif
   );

`ifndef VME_REG_BANK_WSTROBE_EN
   assign a_strb = '0;
   assign b_strb = '0;
`endif

   // ---------------- reference model ----------------
   typedef struct {
      int          due;
      int          addr;
      logic [31:0] data;
   } wr_t;

   wr_t         wq[$];
   int          nregs [2] = '{4, 3};
   logic [15:0] rst_val [2][4] = '{'{16'hA001, 16'hB002, 16'hC003, 16'hD004},
                                   '{16'h1A1A, 16'h2B2B, 16'h3C3C, 16'h0000}};
   logic [15:0] mem [2][4];
   logic [31:0] rd_hold [2];
   logic [31:0] rd_next_val [2];
   bit          rd_next_err [2];
   bit          rd_next_v;
   bit          rd_cur_v;
   bit          rd_cur_err [2];
   bit          wdue;
   int          waddr;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      wq.delete();
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < 4; r++) mem[d][r] = rst_val[d][r];
         rd_hold[d] = '0;
      end
      rd_next_v = 1'b0;
      rd_cur_v  = 1'b0;
      wdue      = 1'b0;
   endtask

   task automatic check_dut(input int d, input logic [31:0] rdd, input logic rdone,
                            input logic rerr, input logic wdone, input logic werr,
                            input logic [63:0] regs, input logic [3:0] strb);
      logic [63:0] exp_regs;
      bit          mapped;
      string       p;
      p = (d == 0) ? "a" : "b";
      exp_regs = '0;
      for (int r = 0; r < nregs[d]; r++) exp_regs[r*16 +: 16] = mem[d][r];
      mapped = wdue && (waddr < nregs[d]);
      check_val({p, "_regs"},   regs,  exp_regs);
      check_val({p, "_rddone"}, 64'(rdone), 64'(rd_cur_v));
      check_val({p, "_rderr"},  64'(rerr),  64'(rd_cur_v && rd_cur_err[d]));
      check_val({p, "_rddata"}, 64'(rdd),   64'(rd_hold[d]));
      check_val({p, "_wrdone"}, 64'(wdone), 64'(wdue));
      check_val({p, "_wrerr"},  64'(werr),  64'(wdue && !mapped));
`ifdef VME_REG_BANK_WSTROBE_EN
      check_val({p, "_strobe"}, 64'(strb), mapped ? (64'd1 << waddr) : 64'd0);
`else
      if (strb != 4'd0) check_val({p, "_strobe"}, 64'(strb), 64'd0);
`endif
   endtask

   task automatic check_all();
      check_dut(0, a_rd_data, a_rd_done, a_rd_err, a_wr_done, a_wr_err, a_regs, a_strb);
      check_dut(1, b_rd_data, b_rd_done, b_rd_err, b_wr_done, b_wr_err, 64'(b_regs), {1'b0, b_strb});
   endtask

   // One clock cycle: apply due model events, compare, then drive this cycle's request
   task automatic cycle(input bit rd, input bit wr, input int addr, input logic [31:0] data);
      @(posedge Clk);
      #1;
      cyc++;
      wdue = 1'b0;
      while (wq.size() > 0 && wq[0].due <= cyc) begin
         wr_t w;
         w = wq.pop_front();
         wdue  = 1'b1;
         waddr = w.addr;
         for (int d = 0; d < 2; d++)
            if (w.addr < nregs[d]) mem[d][w.addr] = w.data[15:0];
      end
      rd_cur_v = rd_next_v;
      for (int d = 0; d < 2; d++) begin
         rd_cur_err[d] = rd_next_err[d];
         if (rd_next_v) rd_hold[d] = rd_next_val[d];
      end
      check_all();

      rd_next_v = rd;
      for (int d = 0; d < 2; d++) begin
         rd_next_err[d] = (addr >= nregs[d]);
         rd_next_val[d] = (addr < nregs[d]) ? {16'h0000, mem[d][addr]} : 32'h0;
      end
      if (wr) wq.push_back('{cyc + 2, addr, data});
      VMERdMem  = rd;
      VMEWrMem  = wr;
      VMEAddr   = 2'(addr);
      VMEWrData = data;
   endtask

   task automatic do_reset();
      @(posedge Clk);
      #1;
      cyc++;
      rst_n    = 1'b0;
      VMERdMem = 1'b0;
      VMEWrMem = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge Clk);
      #1;
      cyc++;
      check_all();
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      do_reset();

      // Reset values readable back-to-back
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, i, 32'h0);
      // Upper write data ignored; read in T+1 sees old, read in T+2 sees new
      cycle(1'b0, 1'b1, 2, 32'hFFFF_1234);
      cycle(1'b1, 1'b0, 2, 32'h0);
      cycle(1'b1, 1'b0, 2, 32'h0);
      cycle(1'b0, 1'b0, 0, 32'h0);
      // Same-cycle read and write to one register
      cycle(1'b1, 1'b1, 1, 32'h0000_5555);
      cycle(1'b0, 1'b0, 0, 32'h0);
      cycle(1'b0, 1'b0, 0, 32'h0);
      // Address 3: mapped on bank a, unmapped on bank b
      cycle(1'b1, 1'b1, 3, 32'h0000_7777);
      cycle(1'b0, 1'b0, 0, 32'h0);
      cycle(1'b0, 1'b0, 0, 32'h0);
      // Back-to-back writes 0..3
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, i, 32'h1111 * (i + 1));
      cycle(1'b0, 1'b0, 0, 32'h0);
      cycle(1'b0, 1'b0, 0, 32'h0);
      // Reset one cycle after a write drops it
      cycle(1'b0, 1'b1, 0, 32'h0000_BEEF);
      do_reset();
      cycle(1'b1, 1'b0, 0, 32'h0);
      cycle(1'b0, 1'b0, 0, 32'h0);
      cycle(1'b0, 1'b0, 0, 32'h0);

      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 59) == 0) begin
            do_reset();
         end else begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), $urandom);
         end
      end
      cycle(1'b0, 1'b0, 0, 32'h0);
      cycle(1'b0, 1'b0, 0, 32'h0);
      cycle(1'b0, 1'b0, 0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
